// File: rtl/skip_table_loader.sv
// Skip-table loader: copies (PC, control) entry pairs from data memory into the
// fetch-stage skip table, or bulk-invalidates every entry.
//
// state       | meaning
// ------------+------------------------------------------------------------
// IDLE        | waiting for StartIn; command checked here
// RD_PC_REQ   | read request for entry word 0 (PC)
// RD_PC_WAIT  | waiting for PC read data
// RD_CTL_REQ  | read request for entry word 1 (control)
// RD_CTL_WAIT | waiting for control read data
// WR_INV      | write control word with valid cleared
// WR_PC       | write PC word
// WR_CTL      | write control word as read
// CLR         | invalidate one entry per cycle, idx 0..N-1
// DONE        | one-cycle completion pulse
module skip_table_loader #(
    parameter int unsigned SKIP_TABLE_SIZE = 16,
    parameter logic [31:0] TABLE_BLOCK_IDX = 32'hFFFF_FFFF
) (
    input  logic                                 ClockIn,
    input  logic                                 AsyncResetIn,
    input  logic                                 StartIn,
    input  logic                                 ClearModeIn,
    input  logic [31:0]                          SrcBaseIn,
    input  logic [$clog2(SKIP_TABLE_SIZE)-1:0]   StartIdxIn,
    input  logic [$clog2(SKIP_TABLE_SIZE):0]     EntryCountIn,
    output logic                                 MemReqOut,
    output logic [31:0]                          MemAddrOut,
    input  logic                                 MemReqReadyIn,
    input  logic                                 MemRespValidIn,
    input  logic [31:0]                          MemRespDataIn,
    output logic                                 WriteEnOut,
    output logic [31:0]                          WriteAddressOut,
    output logic [31:0]                          WriteDataOut,
    output logic                                 BusyOut,
    output logic                                 DoneOut,
    output logic                                 ErrorOut
);
    localparam int IW = $clog2(SKIP_TABLE_SIZE);
    localparam int BW = 32 - IW - 2;

    typedef enum logic [3:0] {
        IDLE, RD_PC_REQ, RD_PC_WAIT, RD_CTL_REQ, RD_CTL_WAIT,
        WR_INV, WR_PC, WR_CTL, CLR, DONE
    } state_t;

    state_t        state, state_nxt;
    logic [IW-1:0] idx;
    logic [IW:0]   remaining;
    logic [31:0]   rd_base;
    logic [31:0]   pc_q, ctl_q;
    logic [31:0]   wr_addr_q, wr_data_q;
    logic [31:0]   wr_addr, wr_data;
    logic          err_q;
    logic [IW+1:0] end_idx;
    logic          cmd_err;

    assign end_idx = {2'b00, StartIdxIn} + {1'b0, EntryCountIn};
    assign cmd_err = (SrcBaseIn[2:0] != 3'b000) || (end_idx > (IW+2)'(SKIP_TABLE_SIZE));

    // Word 1 of the current entry sits 4 bytes above the 8-byte-aligned base.
    assign MemAddrOut      = rd_base | {29'd0, (state == RD_CTL_REQ), 2'b00};
    assign WriteAddressOut = wr_addr;
    assign WriteDataOut    = wr_data;
    assign ErrorOut        = err_q;

    always_comb begin
        state_nxt  = state;
        MemReqOut  = 1'b0;
        WriteEnOut = 1'b0;
        DoneOut    = 1'b0;
        BusyOut    = (state != IDLE);
        wr_addr    = wr_addr_q;
        wr_data    = wr_data_q;
        case (state)
            IDLE: begin
                if (StartIn) begin
                    if (ClearModeIn)
                        state_nxt = CLR;
                    else if (!cmd_err)
                        state_nxt = (EntryCountIn == '0) ? DONE : RD_PC_REQ;
                end
            end
            RD_PC_REQ: begin
                MemReqOut = 1'b1;
                if (MemReqReadyIn) state_nxt = RD_PC_WAIT;
            end
            RD_PC_WAIT: if (MemRespValidIn) state_nxt = RD_CTL_REQ;
            RD_CTL_REQ: begin
                MemReqOut = 1'b1;
                if (MemReqReadyIn) state_nxt = RD_CTL_WAIT;
            end
            RD_CTL_WAIT: if (MemRespValidIn) state_nxt = WR_INV;
            WR_INV: begin
                // Invalidate first so the entry can never hit with a stale PC.
                WriteEnOut = 1'b1;
                wr_addr    = {TABLE_BLOCK_IDX[BW-1:0], 1'b0, idx, 1'b1};
                wr_data    = {1'b0, ctl_q[30:0]};
                state_nxt  = WR_PC;
            end
            WR_PC: begin
                WriteEnOut = 1'b1;
                wr_addr    = {TABLE_BLOCK_IDX[BW-1:0], 1'b0, idx, 1'b0};
                wr_data    = pc_q;
                state_nxt  = WR_CTL;
            end
            WR_CTL: begin
                WriteEnOut = 1'b1;
                wr_addr    = {TABLE_BLOCK_IDX[BW-1:0], 1'b0, idx, 1'b1};
                wr_data    = ctl_q;
                state_nxt  = (remaining == (IW+1)'(1)) ? DONE : RD_PC_REQ;
            end
            CLR: begin
                WriteEnOut = 1'b1;
                wr_addr    = {TABLE_BLOCK_IDX[BW-1:0], 1'b0, idx, 1'b1};
                wr_data    = 32'd0;
                if (idx == IW'(SKIP_TABLE_SIZE - 1)) state_nxt = DONE;
            end
            DONE: begin
                DoneOut   = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge ClockIn or negedge AsyncResetIn) begin
        if (!AsyncResetIn) begin
            state     <= IDLE;
            idx       <= '0;
            remaining <= '0;
            rd_base   <= '0;
            pc_q      <= '0;
            ctl_q     <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state     <= state_nxt;
            wr_addr_q <= wr_addr;
            wr_data_q <= wr_data;
            err_q     <= (state == IDLE) && StartIn && !ClearModeIn && cmd_err;
            case (state)
                IDLE: begin
                    if (StartIn) begin
                        idx       <= ClearModeIn ? '0 : StartIdxIn;
                        rd_base   <= SrcBaseIn;
                        remaining <= EntryCountIn;
                    end
                end
                RD_PC_WAIT:  if (MemRespValidIn) pc_q <= MemRespDataIn;
                RD_CTL_WAIT: if (MemRespValidIn) ctl_q <= MemRespDataIn;
                WR_CTL: begin
                    idx       <= idx + 1'b1;
                    rd_base   <= rd_base + 32'd8;
                    remaining <= remaining - 1'b1;
                end
                CLR: idx <= idx + 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_skip_table_loader.sv
// Directed bench for skip_table_loader: memory responder with optional stalls,
// write/pulse monitor and hand-derived expected write sequences.
module tb_skip_table_loader;
    logic        ClockIn = 1'b0;
    logic        AsyncResetIn = 1'b0;
    logic        StartIn = 1'b0;
    logic        ClearModeIn = 1'b0;
    logic [31:0] SrcBaseIn = '0;
    logic [3:0]  StartIdxIn = '0;
    logic [4:0]  EntryCountIn = '0;
    logic        MemReqOut;
    logic [31:0] MemAddrOut;
    logic        MemReqReadyIn = 1'b0;
    logic        MemRespValidIn = 1'b0;
    logic [31:0] MemRespDataIn = '0;
    logic        WriteEnOut;
    logic [31:0] WriteAddressOut;
    logic [31:0] WriteDataOut;
    logic        BusyOut;
    logic        DoneOut;
    logic        ErrorOut;

    skip_table_loader dut (
        .ClockIn(ClockIn), .AsyncResetIn(AsyncResetIn), .StartIn(StartIn),
        .ClearModeIn(ClearModeIn), .SrcBaseIn(SrcBaseIn), .StartIdxIn(StartIdxIn),
        .EntryCountIn(EntryCountIn), .MemReqOut(MemReqOut), .MemAddrOut(MemAddrOut),
        .MemReqReadyIn(MemReqReadyIn), .MemRespValidIn(MemRespValidIn),
        .MemRespDataIn(MemRespDataIn), .WriteEnOut(WriteEnOut),
        .WriteAddressOut(WriteAddressOut), .WriteDataOut(WriteDataOut),
        .BusyOut(BusyOut), .DoneOut(DoneOut), .ErrorOut(ErrorOut)
    );

    always #5 ClockIn = ~ClockIn;

    int cyc = 0;
    always @(posedge ClockIn) cyc <= cyc + 1;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Entry memory: two fixed words for the first test, a formula elsewhere.
    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (a == 32'h1000) return 32'h0000_0400;
        if (a == 32'h1004) return 32'h8400_0005;
        return a[2] ? (a ^ 32'h8000_0000) : (a + 32'h10);
    endfunction

    function automatic logic [31:0] taddr(input int idx, input int off);
        return 32'hFFFF_FFC0 | 32'(idx << 1) | 32'(off);
    endfunction

    logic [31:0] wa_q[$];
    logic [31:0] wd_q[$];
    int          wc_q[$];
    logic [31:0] req_q[$];
    int          done_cnt = 0;
    int          err_cnt = 0;
    int          done_cyc = 0;
    int          start_cyc = 0;

    int          stall_cycles = 0;
    int          stall_cnt = 0;
    int          hold_after = 1000000;
    logic        pending = 1'b0;
    logic [31:0] pend_addr = '0;
    logic [31:0] stall_addr = '0;

    // Responder: one cycle of response latency after acceptance, optional stalls.
    initial begin
        forever begin
            @(negedge ClockIn);
            if (pending && req_q.size() < hold_after) begin
                MemRespValidIn = 1'b1;
                MemRespDataIn  = mem_rd(pend_addr);
                pending        = 1'b0;
            end else begin
                MemRespValidIn = 1'b0;
            end
            if (MemReqOut && stall_cnt < stall_cycles) begin
                if (stall_cnt == 0) stall_addr = MemAddrOut;
                else chk("req_addr_stable", MemAddrOut, stall_addr);
                MemReqReadyIn = 1'b0;
                stall_cnt++;
            end else begin
                MemReqReadyIn = 1'b1;
                if (MemReqOut) begin
                    if (stall_cnt > 0) chk("req_addr_held", MemAddrOut, stall_addr);
                    req_q.push_back(MemAddrOut);
                    pend_addr = MemAddrOut;
                    pending   = 1'b1;
                    stall_cnt = 0;
                end
            end
        end
    end

    always @(negedge ClockIn) begin
        if (WriteEnOut) begin
            wa_q.push_back(WriteAddressOut);
            wd_q.push_back(WriteDataOut);
            wc_q.push_back(cyc);
        end
        if (DoneOut) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (ErrorOut) err_cnt++;
    end

    task automatic clear_logs();
        wa_q.delete(); wd_q.delete(); wc_q.delete(); req_q.delete();
        done_cnt = 0;
        err_cnt  = 0;
    endtask

    task automatic start_cmd(input logic clr, input logic [31:0] base,
                             input logic [3:0] sidx, input logic [4:0] cnt);
        @(negedge ClockIn);
        StartIn = 1'b1; ClearModeIn = clr; SrcBaseIn = base;
        StartIdxIn = sidx; EntryCountIn = cnt;
        @(negedge ClockIn);
        StartIn = 1'b0;
        start_cyc = cyc;
    endtask

    task automatic wait_end(input string tag);
        int n = 0;
        while (!((done_cnt + err_cnt) > 0 && !BusyOut) && n < 600) begin
            @(negedge ClockIn);
            n++;
        end
        if (n >= 600) chk({tag, "_timeout"}, 32'd0, 32'd1);
        repeat (3) @(negedge ClockIn);
    endtask

    task automatic chk_write(input string tag, input int k, input logic [31:0] a, input logic [31:0] d);
        logic [31:0] ga, gd;
        ga = (k < wa_q.size()) ? wa_q[k] : 32'hxxxx_xxxx;
        gd = (k < wd_q.size()) ? wd_q[k] : 32'hxxxx_xxxx;
        chk($sformatf("%s_w%0d_addr", tag, k), ga, a);
        chk($sformatf("%s_w%0d_data", tag, k), gd, d);
    endtask

    task automatic chk_req(input string tag, input int k, input logic [31:0] a);
        logic [31:0] g;
        g = (k < req_q.size()) ? req_q[k] : 32'hxxxx_xxxx;
        chk($sformatf("%s_req%0d", tag, k), g, a);
    endtask

    task automatic chk_outs_zero(input string tag);
        chk({tag, "_flags"}, {27'd0, MemReqOut, WriteEnOut, BusyOut, DoneOut, ErrorOut}, 32'd0);
        chk({tag, "_memaddr"}, MemAddrOut, 32'd0);
        chk({tag, "_waddr"}, WriteAddressOut, 32'd0);
        chk({tag, "_wdata"}, WriteDataOut, 32'd0);
    endtask

    task automatic load_one_3(input string tag);
        clear_logs();
        start_cmd(1'b0, 32'h1000, 4'd3, 5'd1);
        wait_end(tag);
        chk({tag, "_nreq"}, 32'(req_q.size()), 32'd2);
        chk_req(tag, 0, 32'h1000);
        chk_req(tag, 1, 32'h1004);
        chk({tag, "_nwr"}, 32'(wa_q.size()), 32'd3);
        chk_write(tag, 0, taddr(3, 1), 32'h0400_0005);
        chk_write(tag, 1, taddr(3, 0), 32'h0000_0400);
        chk_write(tag, 2, taddr(3, 1), 32'h8400_0005);
        chk({tag, "_done"}, 32'(done_cnt), 32'd1);
        chk({tag, "_err"}, 32'(err_cnt), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int k;
        repeat (3) @(negedge ClockIn);
        chk_outs_zero("reset");
        AsyncResetIn = 1'b1;
        repeat (2) @(negedge ClockIn);

        // Single entry, zero memory wait.
        load_one_3("t1");
        chk("t1_latency", 32'(done_cyc - start_cyc), 32'd7);

        // Four entries ending exactly at the top of the table, stalled requests,
        // plus a stray Start while busy.
        clear_logs();
        stall_cycles = 2;
        start_cmd(1'b0, 32'h2000, 4'd12, 5'd4);
        repeat (5) @(negedge ClockIn);
        StartIn = 1'b1; ClearModeIn = 1'b1;
        @(negedge ClockIn);
        StartIn = 1'b0; ClearModeIn = 1'b0;
        wait_end("t2");
        stall_cycles = 0;
        chk("t2_nreq", 32'(req_q.size()), 32'd8);
        for (int i = 0; i < 8; i++) chk_req("t2", i, 32'h2000 + 32'(4 * i));
        chk("t2_nwr", 32'(wa_q.size()), 32'd12);
        for (int e = 0; e < 4; e++) begin
            logic [31:0] pc, ctl;
            pc  = 32'h2010 + 32'(8 * e);
            ctl = 32'h8000_2004 + 32'(8 * e);
            chk_write("t2", 3 * e,     taddr(12 + e, 1), {1'b0, ctl[30:0]});
            chk_write("t2", 3 * e + 1, taddr(12 + e, 0), pc);
            chk_write("t2", 3 * e + 2, taddr(12 + e, 1), ctl);
        end
        chk("t2_done", 32'(done_cnt), 32'd1);
        chk("t2_err", 32'(err_cnt), 32'd0);

        // Rejected and empty commands.
        clear_logs();
        start_cmd(1'b0, 32'h1000, 4'd14, 5'd3);
        wait_end("e_range");
        chk("e_range_err", 32'(err_cnt), 32'd1);
        chk("e_range_done", 32'(done_cnt), 32'd0);
        chk("e_range_nwr", 32'(wa_q.size()), 32'd0);
        chk("e_range_nreq", 32'(req_q.size()), 32'd0);

        clear_logs();
        start_cmd(1'b0, 32'h1004, 4'd0, 5'd1);
        wait_end("e_align");
        chk("e_align_err", 32'(err_cnt), 32'd1);
        chk("e_align_nwr", 32'(wa_q.size()), 32'd0);
        chk("e_align_nreq", 32'(req_q.size()), 32'd0);

        clear_logs();
        start_cmd(1'b0, 32'h1000, 4'd0, 5'd0);
        wait_end("e_zero");
        chk("e_zero_done", 32'(done_cnt), 32'd1);
        chk("e_zero_err", 32'(err_cnt), 32'd0);
        chk("e_zero_nwr", 32'(wa_q.size()), 32'd0);
        chk("e_zero_nreq", 32'(req_q.size()), 32'd0);

        // Bulk invalidate; other command fields deliberately invalid.
        clear_logs();
        start_cmd(1'b1, 32'h0123_4567, 4'd5, 5'd7);
        wait_end("clr");
        chk("clr_nwr", 32'(wa_q.size()), 32'd16);
        for (int i = 0; i < 16; i++) begin
            chk_write("clr", i, taddr(i, 1), 32'd0);
            k = (i < wc_q.size()) ? wc_q[i] - wc_q[0] : -1;
            chk($sformatf("clr_w%0d_cycle", i), 32'(k), 32'(i));
        end
        chk("clr_done", 32'(done_cnt), 32'd1);
        chk("clr_err", 32'(err_cnt), 32'd0);
        chk("clr_nreq", 32'(req_q.size()), 32'd0);

        // Reset while waiting on the control word of the second entry.
        clear_logs();
        hold_after = 4;
        start_cmd(1'b0, 32'h3000, 4'd0, 5'd4);
        k = 0;
        while (req_q.size() < 4 && k < 100) begin
            @(negedge ClockIn);
            k++;
        end
        if (k >= 100) chk("rst_mid_timeout", 32'd0, 32'd1);
        @(posedge ClockIn);
        #2 AsyncResetIn = 1'b0;
        #1 chk_outs_zero("rst_mid");
        chk("rst_mid_nwr", 32'(wa_q.size()), 32'd3);
        repeat (2) @(negedge ClockIn);
        AsyncResetIn = 1'b1;
        hold_after = 1000000;
        repeat (10) @(negedge ClockIn);
        chk("rst_late_nwr", 32'(wa_q.size()), 32'd3);
        chk("rst_late_busy", 32'(BusyOut), 32'd0);
        chk("rst_late_done", 32'(done_cnt), 32'd0);

        load_one_3("t_after_rst");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
